// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time baud divisor, framing/parity/break detection and a
// show-ahead FIFO drained over a valid/ready handshake.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sig_rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    output logic [DATA_WIDTH-1:0]         data_rx,
    output logic [2:0]                    err_rx,
    output logic                          valid_rx,
    input  logic                          ready_rx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 3;
    localparam int IW = 4;
    localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                  r_state, w_next;
    logic [1:0]              r_sync;
    logic [1:0]              r_filt;
    logic                    r_sig_prev;
    logic [1:0]              r_fill;
    logic                    r_seen_high;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [IW-1:0]           r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par;
    logic                    r_stop0;
    logic                    r_ferr;

    logic                    w_sig_f;
    logic                    w_fall;
    logic [DIV_WIDTH-1:0]    w_div_cl;
    logic                    w_tick;
    logic                    w_last_data;
    logic                    w_last_stop;
    logic                    w_write;
    logic                    w_first_stop;
    logic                    w_brk;
    logic                    w_ferr;
    logic                    w_px;
    logic                    w_perr;
    logic [EW-1:0]           w_entry;

    // Majority of three consecutive synchronised samples; sig_f settles 3 cycles after sig_rx.
    assign w_sig_f = (r_sync[1] & r_filt[0]) | (r_sync[1] & r_filt[1]) | (r_filt[0] & r_filt[1]);

    // r_fill keeps the reset-time ones of the filter from counting as a seen-high line.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync      <= 2'b11;
            r_filt      <= 2'b11;
            r_sig_prev  <= 1'b1;
            r_fill      <= 2'd0;
            r_seen_high <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], sig_rx};
            r_filt     <= {r_filt[0], r_sync[1]};
            r_sig_prev <= w_sig_f;
            if (r_fill != 2'd3)
                r_fill <= r_fill + 2'd1;
            if (r_fill == 2'd3 && w_sig_f)
                r_seen_high <= 1'b1;
        end
    end

    assign w_fall      = r_seen_high & r_sig_prev & ~w_sig_f;
    assign w_div_cl    = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;
    assign w_tick      = (r_cnt == '0);
    assign w_last_data = (r_idx == IW'(DATA_WIDTH - 1));
    assign w_last_stop = (r_idx == IW'(STOP_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_tick) w_next = w_sig_f ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && w_last_data) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_next = S_STOP;
            S_STOP:   if (w_tick && w_last_stop) w_next = w_brk ? S_BREAK : S_IDLE;
            S_BREAK:  if (w_sig_f) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_write      = (r_state == S_STOP) && w_tick && w_last_stop;
        w_first_stop = (STOP_BITS == 1) ? w_sig_f : r_stop0;
        w_brk        = (r_shift == '0) && ((PARITY == 0) || !r_par) && !w_first_stop;
        w_ferr       = r_ferr | ~w_sig_f | w_brk;
        w_px         = (^r_shift) ^ r_par;
        w_perr       = (PARITY == 1) ? w_px : (PARITY == 2) ? ~w_px : 1'b0;
        w_entry      = {w_brk, w_perr, w_ferr, r_shift};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div   <= DIV_WIDTH'(4);
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_stop0 <= 1'b1;
            r_ferr  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_div  <= w_div_cl;
                r_cnt  <= (w_div_cl >> 1) - DIV_WIDTH'(1);
                r_idx  <= '0;
                r_ferr <= 1'b0;
            end
        end else if (r_state != S_BREAK) begin
            if (!w_tick) begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end else begin
                r_cnt <= r_div - DIV_WIDTH'(1);
                case (r_state)
                    S_START:  r_idx <= '0;
                    S_DATA: begin
                        r_shift <= {w_sig_f, r_shift[DATA_WIDTH-1:1]};
                        r_idx   <= w_last_data ? '0 : r_idx + IW'(1);
                    end
                    S_PARITY: r_par <= w_sig_f;
                    S_STOP: begin
                        r_idx <= r_idx + IW'(1);
                        if (r_idx == '0)
                            r_stop0 <= w_sig_f;
                        if (!w_sig_f)
                            r_ferr <= 1'b1;
                    end
                    default: r_idx <= r_idx;
                endcase
            end
        end
    end

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [AW:0]   w_count;
    logic          w_full, w_pop, w_push, w_drop;
    logic [EW-1:0] w_head;

    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (w_count == L_FULL);
    assign valid_rx = (w_count != '0);
    assign w_pop    = valid_rx & ready_rx;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign w_push   = w_write & (~w_full | w_pop);
    assign w_drop   = w_write & w_full & ~w_pop;
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    assign data_rx    = valid_rx ? w_head[DATA_WIDTH-1:0] : '0;
    assign err_rx     = valid_rx ? w_head[EW-1:DATA_WIDTH] : 3'b000;
    assign fifo_count = w_count;

    always_ff @(posedge clk) begin
        if (rstn && w_push)
            r_mem[r_wptr[AW-1:0]] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
            if (w_drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule
